// File: rtl/draw_rect.sv
// draw_rect: rectangle rasteriser streaming one pixel per clock to the VGA adapter.
// Supports solid fill or 1-pixel outline, clips against the visible screen,
// and signals completion with a one-cycle done pulse.
module draw_rect #(
    parameter int unsigned X_W      = 9,
    parameter int unsigned Y_W      = 8,
    parameter int unsigned SIZE_W   = 5,
    parameter int unsigned COLOR_W  = 3,
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [X_W-1:0]     bias_x,
    input  logic [Y_W-1:0]     bias_y,
    input  logic [SIZE_W-1:0]  width,
    input  logic [SIZE_W-1:0]  height,
    input  logic [COLOR_W-1:0] color,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam int unsigned XS_W = X_W + 1;
    localparam int unsigned YS_W = Y_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_e;

    state_e              state_q;
    logic [SIZE_W-1:0]   dx_q, dy_q;
    logic [X_W-1:0]      bx_q;
    logic [Y_W-1:0]      by_q;
    logic [SIZE_W-1:0]   w_q, h_q;
    logic [COLOR_W-1:0]  col_q;
    logic                mode_q;
    logic                fin_q;

    logic [X_W-1:0]      cur_bx_c;
    logic [Y_W-1:0]      cur_by_c;
    logic [SIZE_W-1:0]   cur_w_c, cur_h_c, cur_dx_c, cur_dy_c;
    logic                cur_mode_c;
    logic [XS_W-1:0]     sum_x_c;
    logic [YS_W-1:0]     sum_y_c;
    logic                on_screen_c, on_edge_c, pix_plot_c, last_c, row_end_c;
    logic [SIZE_W-1:0]   dx_d, dy_d;

    // Pixel being emitted this edge: request inputs at pixel (0,0) when idle, latched copy when drawing
    always_comb begin
        cur_bx_c   = bias_x;
        cur_by_c   = bias_y;
        cur_w_c    = width;
        cur_h_c    = height;
        cur_mode_c = mode;
        cur_dx_c   = '0;
        cur_dy_c   = '0;
        if (state_q == S_DRAW) begin
            cur_bx_c   = bx_q;
            cur_by_c   = by_q;
            cur_w_c    = w_q;
            cur_h_c    = h_q;
            cur_mode_c = mode_q;
            cur_dx_c   = dx_q;
            cur_dy_c   = dy_q;
        end
        // one extra bit so pixels past the coordinate range clip instead of wrapping on screen
        sum_x_c     = XS_W'(cur_bx_c) + XS_W'(cur_dx_c);
        sum_y_c     = YS_W'(cur_by_c) + YS_W'(cur_dy_c);
        on_screen_c = (sum_x_c < XS_W'(SCREEN_W)) && (sum_y_c < YS_W'(SCREEN_H));
        row_end_c   = (cur_dx_c == cur_w_c - SIZE_W'(1));
        on_edge_c   = (cur_dx_c == '0) || row_end_c || (cur_dy_c == '0) ||
                      (cur_dy_c == cur_h_c - SIZE_W'(1));
        pix_plot_c  = on_screen_c && (!cur_mode_c || on_edge_c);
        last_c      = row_end_c && (cur_dy_c == cur_h_c - SIZE_W'(1));
        dx_d        = cur_dx_c + SIZE_W'(1);
        dy_d        = cur_dy_c;
        if (row_end_c) begin
            dx_d = '0;
            dy_d = cur_dy_c + SIZE_W'(1);
        end
    end

    // Control FSM, request latch, raster counters and registered pixel outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            dx_q      <= '0;
            dy_q      <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            mode_q    <= 1'b0;
            fin_q     <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        if ((width == '0) || (height == '0)) begin
                            done <= 1'b1;
                        end else begin
                            bx_q      <= bias_x;
                            by_q      <= bias_y;
                            w_q       <= width;
                            h_q       <= height;
                            col_q     <= color;
                            mode_q    <= mode;
                            vga_x     <= sum_x_c[X_W-1:0];
                            vga_y     <= sum_y_c[Y_W-1:0];
                            vga_color <= color;
                            plot      <= pix_plot_c;
                            busy      <= 1'b1;
                            fin_q     <= last_c;
                            dx_q      <= dx_d;
                            dy_q      <= dy_d;
                            state_q   <= S_DRAW;
                        end
                    end
                end
                S_DRAW: begin
                    if (abort || fin_q) begin
                        plot    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= !abort;
                        fin_q   <= 1'b0;
                        dx_q    <= '0;
                        dy_q    <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        vga_x     <= sum_x_c[X_W-1:0];
                        vga_y     <= sum_y_c[Y_W-1:0];
                        vga_color <= col_q;
                        plot      <= pix_plot_c;
                        fin_q     <= last_c;
                        dx_q      <= dx_d;
                        dy_q      <= dy_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_rect.sv
// Directed testbench for draw_rect.
module tb_draw_rect;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mode = 1'b0;
    logic [8:0] bias_x = '0;
    logic [7:0] bias_y = '0;
    logic [4:0] width = '0;
    logic [4:0] height = '0;
    logic [2:0] color = '0;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_color;
    logic       plot;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    draw_rect dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .bias_x    (bias_x),
        .bias_y    (bias_y),
        .width     (width),
        .height    (height),
        .color     (color),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Draw one rectangle; scramble request inputs while drawing; hand-computed plot count
    task automatic run_rect(input int bx, input int by, input int w, input int h,
                            input int col, input int md, input int exp_plots);
        int plots;
        int dx, dy, ex, ey, ep;
        bias_x = 9'(bx); bias_y = 8'(by); width = 5'(w); height = 5'(h);
        color = 3'(col); mode = md[0]; start = 1'b1;
        tick();
        start = 1'b0;
        bias_x = ~9'(bx); bias_y = ~8'(by); width = 5'd31; height = 5'd31;
        color = ~3'(col); mode = ~md[0];
        plots = 0;
        for (int p = 0; p < w * h; p++) begin
            dx = p % w;
            dy = p / w;
            ex = bx + dx;
            ey = by + dy;
            ep = (ex < 320 && ey < 240 &&
                  (md == 0 || dx == 0 || dx == w - 1 || dy == 0 || dy == h - 1)) ? 1 : 0;
            check("pix_plot", int'(plot), ep);
            check("pix_x", int'(vga_x), ex % 512);
            check("pix_y", int'(vga_y), ey % 256);
            check("pix_color", int'(vga_color), col);
            check("pix_busy", int'(busy), 1);
            check("pix_done", int'(done), 0);
            plots += int'(plot);
            tick();
        end
        check("plot_count", plots, exp_plots);
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("done_plot", int'(plot), 0);
        tick();
        check("done_drop", int'(done), 0);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_x", int'(vga_x), 0);
        check("rst_y", int'(vga_y), 0);
        check("rst_col", int'(vga_color), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        #2 resetn = 1'b1;
        tick();

        // 8x8 fill, 4x3 outline, clipping at screen corner and past X_W range
        run_rect(10, 20, 8, 8, 5, 0, 64);
        run_rect(0, 0, 4, 3, 7, 1, 10);
        run_rect(318, 238, 4, 4, 2, 0, 4);
        run_rect(510, 0, 4, 1, 1, 0, 0);

        // zero-size request
        width = 5'd0; height = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        check("zero_plot", int'(plot), 0);
        tick();
        check("zero_done_drop", int'(done), 0);
        check("zero_busy2", int'(busy), 0);

        // 1x1
        run_rect(5, 5, 1, 1, 4, 0, 1);

        // abort at pixel 20 of an 8x8
        bias_x = 9'd10; bias_y = 8'd20; width = 5'd8; height = 5'd8;
        color = 3'd3; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) tick();
        check("abort_px_x", int'(vga_x), 14);
        check("abort_px_y", int'(vga_y), 22);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        tick();
        check("abort_done2", int'(done), 0);
        check("abort_busy2", int'(busy), 0);

        // start held through a 2x1 draw and its done cycle; mid-draw changes ignored
        bias_x = 9'd0; bias_y = 8'd0; width = 5'd2; height = 5'd1;
        color = 3'd1; mode = 1'b0; start = 1'b1;
        tick();
        check("hold_p0_x", int'(vga_x), 0);
        check("hold_p0_col", int'(vga_color), 1);
        bias_x = 9'd3; bias_y = 8'd3; width = 5'd1; height = 5'd1; color = 3'd2;
        tick();
        check("hold_p1_x", int'(vga_x), 1);
        check("hold_p1_y", int'(vga_y), 0);
        check("hold_p1_col", int'(vga_color), 1);
        check("hold_p1_plot", int'(plot), 1);
        tick();
        check("hold_done", int'(done), 1);
        check("hold_done_busy", int'(busy), 0);
        tick();
        check("hold_new_x", int'(vga_x), 3);
        check("hold_new_y", int'(vga_y), 3);
        check("hold_new_col", int'(vga_color), 2);
        check("hold_new_plot", int'(plot), 1);
        check("hold_new_busy", int'(busy), 1);
        check("hold_new_done", int'(done), 0);
        start = 1'b0;
        tick();
        check("hold_new_fin", int'(done), 1);
        tick();

        // asynchronous reset mid-rectangle
        bias_x = 9'd10; bias_y = 8'd20; width = 5'd8; height = 5'd8;
        color = 3'd6; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 resetn = 1'b0;
        #1;
        check("arst_x", int'(vga_x), 0);
        check("arst_y", int'(vga_y), 0);
        check("arst_col", int'(vga_color), 0);
        check("arst_plot", int'(plot), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        #2 resetn = 1'b1;
        run_rect(30, 40, 3, 2, 6, 1, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
